pipe_collision_checker: RTL

- Consumer side of the pipe generator's packed position buffers (x/y, 3×11 bit) and pipe count.
- Once per update frame, snapshots the buffers, checks the bird box against each active pipe (one pipe per cycle) and against screen bounds.
- Reports collision to the game FSM and keeps the score.
- Sits between the pipe generator / bird physics and the game status controller.

---
 rtl/pipe_collision_checker_if.sv | 24 ++
 rtl/pipe_collision_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_collision_checker_if.sv
// Signal bundle between the pipe generator / bird physics / game FSM and the collision checker.
// The master side drives the snapshot inputs; the slave side is the checker itself.
interface pipe_collision_checker_if;
    logic        vga_sync;
    logic [2:0]  status;
    logic [2:0]  pipe_cnt;
    logic [32:0] ixbuf;
    logic [32:0] iybuf;
    logic [10:0] bird_y;
    logic        hit;
    logic        hit_pulse;
    logic        scan_done;
    logic [7:0]  score;

    modport master (
        output vga_sync, status, pipe_cnt, ixbuf, iybuf, bird_y,
        input  hit, hit_pulse, scan_done, score
    );

    modport slave (
        input  vga_sync, status, pipe_cnt, ixbuf, iybuf, bird_y,
        output hit, hit_pulse, scan_done, score
    );
endinterface

// File: rtl/pipe_collision_checker.sv
// Per-frame collision scan of the bird box against up to three pipes and the screen bottom.
// state | meaning
// IDLE  | wait for a rising vga_sync while playing
// SNAP  | latch pipe buffers, count and bird_y; evaluate the bottom bound
// CHECK | one pipe per cycle, idx 0..2, only pipes below the latched count
// DONE  | publish hit / score, then back to IDLE
module pipe_collision_checker #(
    parameter int BIRD_X   = 100,
    parameter int BIRD_W   = 34,
    parameter int BIRD_H   = 24,
    parameter int PIPE_W   = 70,
    parameter int GAP      = 120,
    parameter int SCREEN_H = 480
) (
    input  logic              clock,
    input  logic              reset,
    pipe_collision_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SNAP, CHECK, DONE} state_t;

    localparam logic signed [11:0] L_BX    = 12'(BIRD_X);
    localparam logic signed [11:0] L_BX_R  = 12'(BIRD_X + BIRD_W);
    localparam logic signed [11:0] L_BH    = 12'(BIRD_H);
    localparam logic signed [11:0] L_PW    = 12'(PIPE_W);
    localparam logic signed [11:0] L_GAP   = 12'(GAP);
    localparam logic signed [11:0] L_SH    = 12'(SCREEN_H);

    state_t             state_q, state_d;
    logic               sync_q;
    logic [1:0]         idx_q, idx_d;
    logic [32:0]        xbuf_q, xbuf_d;
    logic [32:0]        ybuf_q, ybuf_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [10:0]        bird_y_q, bird_y_d;
    logic               scan_hit_q, scan_hit_d;
    logic               hit_q, hit_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               scan_done_q, scan_done_d;
    logic [7:0]         score_q, score_d;
    logic signed [10:0] prev_x1_q, prev_x1_d;
    logic               was_playing_q, was_playing_d;

    logic               playing;
    logic               start;
    logic [10:0]        x_sel;
    logic [10:0]        y_sel;
    logic signed [11:0] px, py, by, by_in, x1, prev_x1;
    logic               x_ovl, y_out, pipe_hit, bound_hit, crossed;

    assign playing = (bus.status == 3'd2);
    assign start   = bus.vga_sync & ~sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!playing) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = SNAP;
                SNAP:    state_d = CHECK;
                CHECK:   if (idx_q == 2'd2) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        x_sel = xbuf_q[32:22];
        y_sel = ybuf_q[32:22];
        case (idx_q)
            2'd0: begin x_sel = xbuf_q[10:0];  y_sel = ybuf_q[10:0];  end
            2'd1: begin x_sel = xbuf_q[21:11]; y_sel = ybuf_q[21:11]; end
            default: ;
        endcase
    end

    // x is a signed left edge (pipes enter/leave off-screen); y values are unsigned.
    assign px        = {x_sel[10], x_sel};
    assign py        = {1'b0, y_sel};
    assign by        = {1'b0, bird_y_q};
    assign by_in     = {1'b0, bus.bird_y};
    assign x1        = {xbuf_q[10], xbuf_q[10:0]};
    assign prev_x1   = {prev_x1_q[10], prev_x1_q};
    assign x_ovl     = (px < L_BX_R) && ((px + L_PW) > L_BX);
    assign y_out     = (by < py) || ((by + L_BH) > (py + L_GAP));
    assign pipe_hit  = x_ovl && y_out && ({1'b0, idx_q} < cnt_q);
    assign bound_hit = (by_in + L_BH) > L_SH;
    // Only a downward crossing of the bird's left edge counts; a removal shift jumps x1 up.
    assign crossed   = (cnt_q != 3'd0) && ((prev_x1 + L_PW) > L_BX) && ((x1 + L_PW) <= L_BX);

    always_comb begin
        idx_d         = idx_q;
        xbuf_d        = xbuf_q;
        ybuf_d        = ybuf_q;
        cnt_d         = cnt_q;
        bird_y_d      = bird_y_q;
        scan_hit_d    = scan_hit_q;
        hit_d         = hit_q;
        hit_pulse_d   = 1'b0;
        scan_done_d   = 1'b0;
        score_d       = score_q;
        prev_x1_d     = prev_x1_q;
        was_playing_d = was_playing_q;
        case (state_q)
            IDLE: begin
                if (playing && start) begin
                    if (!was_playing_q) score_d = 8'd0;
                    was_playing_d = 1'b1;
                end
            end
            SNAP: begin
                xbuf_d     = bus.ixbuf;
                ybuf_d     = bus.iybuf;
                cnt_d      = bus.pipe_cnt;
                bird_y_d   = bus.bird_y;
                idx_d      = 2'd0;
                scan_hit_d = bound_hit;
            end
            CHECK: begin
                if (pipe_hit) scan_hit_d = 1'b1;
                idx_d = idx_q + 2'd1;
            end
            DONE: begin
                scan_done_d = 1'b1;
                if (scan_hit_q && !hit_q) begin
                    hit_d       = 1'b1;
                    hit_pulse_d = 1'b1;
                end
                if (crossed && !hit_q && (score_q != 8'd255)) score_d = score_q + 8'd1;
                prev_x1_d = xbuf_q[10:0];
            end
            default: ;
        endcase
        if (!playing) begin
            hit_d         = 1'b0;
            hit_pulse_d   = 1'b0;
            scan_done_d   = 1'b0;
            prev_x1_d     = '0;
            was_playing_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q        <= 1'b0;
            idx_q         <= '0;
            xbuf_q        <= '0;
            ybuf_q        <= '0;
            cnt_q         <= '0;
            bird_y_q      <= '0;
            scan_hit_q    <= 1'b0;
            hit_q         <= 1'b0;
            hit_pulse_q   <= 1'b0;
            scan_done_q   <= 1'b0;
            score_q       <= '0;
            prev_x1_q     <= '0;
            was_playing_q <= 1'b0;
        end else begin
            sync_q        <= bus.vga_sync;
            idx_q         <= idx_d;
            xbuf_q        <= xbuf_d;
            ybuf_q        <= ybuf_d;
            cnt_q         <= cnt_d;
            bird_y_q      <= bird_y_d;
            scan_hit_q    <= scan_hit_d;
            hit_q         <= hit_d;
            hit_pulse_q   <= hit_pulse_d;
            scan_done_q   <= scan_done_d;
            score_q       <= score_d;
            prev_x1_q     <= prev_x1_d;
            was_playing_q <= was_playing_d;
        end
    end

    assign bus.hit       = hit_q;
    assign bus.hit_pulse = hit_pulse_q;
    assign bus.scan_done = scan_done_q;
    assign bus.score     = score_q;
endmodule
